// File: rtl/wall_phase_ctrl.sv
// Wall-phase powerup sequencer: stores charges, runs ACTIVE/GRACE/COOLDOWN
// frame timers and drives the collision-disable flag into the maze checker.
module wall_phase_ctrl #(
    parameter int DURATION_FRAMES = 180,
    parameter int GRACE_FRAMES    = 60,
    parameter int COOLDOWN_FRAMES = 120,
    parameter int MAX_CHARGES     = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       pickup,
    input  logic       activate,
    input  logic       in_wall,
    output logic       wallPhase_active,
    output logic       respawn_req,
    output logic [1:0] charges,
    output logic [7:0] frames_left,
    output logic [1:0] phase_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_ACTIVE   = 2'b01,
        S_GRACE    = 2'b10,
        S_COOLDOWN = 2'b11
    } state_t;

    localparam logic [7:0] DUR_LOAD  = 8'(DURATION_FRAMES);
    localparam logic [7:0] GRC_LOAD  = 8'(GRACE_FRAMES);
    localparam logic [7:0] CD_LOAD   = 8'(COOLDOWN_FRAMES);
    localparam logic [2:0] MAX_CHG   = 3'(MAX_CHARGES);

    state_t     r_state;
    logic [7:0] r_timer;
    logic [1:0] r_charges;
    logic       r_active;
    logic       r_respawn;

    logic       w_accept;
    logic       w_last_tick;
    logic [2:0] w_charge_sum;
    logic [1:0] w_charges_next;

    // An activate only counts in IDLE with a charge already stored; a pickup
    // on the same edge cannot fund it.
    assign w_accept       = (r_state == S_IDLE) && activate && (r_charges != 2'd0);
    assign w_last_tick    = frame_tick && (r_timer == 8'd1);
    assign w_charge_sum   = {1'b0, r_charges} + {2'b00, pickup} - {2'b00, w_accept};
    assign w_charges_next = (w_charge_sum > MAX_CHG) ? MAX_CHG[1:0] : w_charge_sum[1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_timer   <= 8'd0;
            r_charges <= 2'd0;
            r_active  <= 1'b0;
            r_respawn <= 1'b0;
        end else begin
            r_charges <= w_charges_next;
            r_respawn <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_ACTIVE;
                        r_timer  <= DUR_LOAD;
                        r_active <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_last_tick) begin
                        if (in_wall) begin
                            r_state <= S_GRACE;
                            r_timer <= GRC_LOAD;
                        end else begin
                            r_state  <= S_COOLDOWN;
                            r_timer  <= CD_LOAD;
                            r_active <= 1'b0;
                        end
                    end else if (frame_tick) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_GRACE: begin
                    // Leaving the wall ends grace immediately, even on a tick.
                    if (!in_wall) begin
                        r_state  <= S_COOLDOWN;
                        r_timer  <= CD_LOAD;
                        r_active <= 1'b0;
                    end else if (w_last_tick) begin
                        r_state   <= S_COOLDOWN;
                        r_timer   <= CD_LOAD;
                        r_active  <= 1'b0;
                        r_respawn <= 1'b1;
                    end else if (frame_tick) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_COOLDOWN: begin
                    if (w_last_tick) begin
                        r_state <= S_IDLE;
                        r_timer <= 8'd0;
                    end else if (frame_tick) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= 8'd0;
                end
            endcase
        end
    end

    assign wallPhase_active = r_active;
    assign respawn_req      = r_respawn;
    assign charges          = r_charges;
    assign frames_left      = r_timer;
    assign phase_state      = r_state;

endmodule

// File: tb/tb_wall_phase_ctrl.sv
// Directed and randomized bench for wall_phase_ctrl against a frame-count model.
module tb_wall_phase_ctrl;

    localparam int DUR = 4;
    localparam int GR  = 2;
    localparam int CD  = 3;
    localparam int MC  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pickup = 1'b0;
    logic       activate = 1'b0;
    logic       in_wall = 1'b0;
    logic       wall_phase_active;
    logic       respawn_req;
    logic [1:0] charges;
    logic [7:0] frames_left;
    logic [1:0] phase_state;

    int errors = 0;
    int checks = 0;

    // Reference: phase 0 idle, 1 active, 2 grace, 3 cooldown.
    int m_ph = 0;
    int m_left = 0;
    int m_ch = 0;
    int m_resp = 0;

    wall_phase_ctrl #(
        .DURATION_FRAMES(DUR),
        .GRACE_FRAMES   (GR),
        .COOLDOWN_FRAMES(CD),
        .MAX_CHARGES    (MC)
    ) dut (
        .Clk             (clk),
        .Reset           (reset),
        .frame_tick      (frame_tick),
        .pickup          (pickup),
        .activate        (activate),
        .in_wall         (in_wall),
        .wallPhase_active(wall_phase_active),
        .respawn_req     (respawn_req),
        .charges         (charges),
        .frames_left     (frames_left),
        .phase_state     (phase_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit tick, input bit pk, input bit act, input bit wall);
        bit acc;
        if (rst) begin
            m_ph = 0; m_left = 0; m_ch = 0; m_resp = 0;
            return;
        end
        acc = (m_ph == 0) && act && (m_ch > 0);
        m_resp = 0;
        m_ch = m_ch + int'(pk) - int'(acc);
        if (m_ch > MC) m_ch = MC;
        if (acc) begin
            m_ph = 1; m_left = DUR;
        end else if (m_ph == 2 && !wall) begin
            m_ph = 3; m_left = CD;
        end else if (m_ph != 0 && tick) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                case (m_ph)
                    1: if (wall) begin m_ph = 2; m_left = GR; end
                       else begin m_ph = 3; m_left = CD; end
                    2: begin m_resp = 1; m_ph = 3; m_left = CD; end
                    default: m_ph = 0;
                endcase
            end
        end
    endtask

    task automatic step(input bit rst, input bit tick, input bit pk, input bit act, input bit wall);
        reset = rst; frame_tick = tick; pickup = pk; activate = act; in_wall = wall;
        @(posedge clk);
        model(rst, tick, pk, act, wall);
        #1;
        check("state", int'(phase_state), m_ph);
        check("frames_left", int'(frames_left), m_left);
        check("charges", int'(charges), m_ch);
        check("active", int'(wall_phase_active), (m_ph == 1 || m_ph == 2) ? 1 : 0);
        check("respawn", int'(respawn_req), m_resp);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        check("rst_state", int'(phase_state), 0);
        check("rst_charges", int'(charges), 0);

        // Activate with no charge is ignored; pickups saturate at MAX.
        step(0, 0, 0, 1, 0);
        check("act_no_charge", int'(phase_state), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        check("pickup_sat", int'(charges), 3);

        // Reset mid-ACTIVE.
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("mid_active_left", int'(frames_left), 2);
        step(1, 0, 0, 0, 0);
        check("rst_mid_state", int'(phase_state), 0);
        check("rst_mid_active", int'(wall_phase_active), 0);
        check("rst_mid_left", int'(frames_left), 0);
        check("rst_mid_charges", int'(charges), 0);

        // One charge: full phase with no wall.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("act_state", int'(phase_state), 1);
        check("act_left", int'(frames_left), 4);
        check("act_charges", int'(charges), 0);
        check("act_active", int'(wall_phase_active), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        check("cd_state", int'(phase_state), 3);
        check("cd_active", int'(wall_phase_active), 0);
        check("cd_left", int'(frames_left), 3);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        check("back_idle", int'(phase_state), 0);

        // Expire in wall, leave wall during grace.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
        check("grace_state", int'(phase_state), 2);
        check("grace_active", int'(wall_phase_active), 1);
        check("grace_left", int'(frames_left), 2);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        check("grace_exit_state", int'(phase_state), 3);
        check("grace_exit_left", int'(frames_left), 3);
        check("grace_exit_resp", int'(respawn_req), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

        // Grace expires with ball still in wall.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        check("grace_tick_left", int'(frames_left), 1);
        check("grace_no_resp", int'(respawn_req), 0);
        step(0, 1, 0, 0, 1);
        check("respawn_pulse", int'(respawn_req), 1);
        check("respawn_state", int'(phase_state), 3);
        step(0, 0, 0, 0, 1);
        check("respawn_once", int'(respawn_req), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

        // Saturated pickup+activate, then ignored activates.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        check("sat_act_state", int'(phase_state), 1);
        check("sat_act_charges", int'(charges), 3);
        step(0, 0, 0, 1, 0);
        check("act_in_active", int'(charges), 3);
        check("act_in_active_left", int'(frames_left), 4);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("act_in_cd_state", int'(phase_state), 3);
        check("act_in_cd_charges", int'(charges), 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
